p405s_dcu_linefillbuf: RTL and testbench
========================================

# p405s_DCU_lineFillBuf

Line-fill buffer for the data cache unit. It captures the eight 32-bit words of a cache-line fill returned from the PLB, critical word first. It forwards any already-received word to the load path as `bypassMuxOut`, the bypass input of the DCU byte-lane output mux. Once the line is complete it drains the words in order to the data array through a req/ack handshake.

## Interface
Parameters:
- `LFB_WORDS`, default 8: words per line. Fixed at 8; the pointers are 3 bits wide.

Ports. All buses are big-endian numbered, bit 0 = MSB. One clock; reset is synchronous and active-high.
- `CB`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fillStart`  in  1  begin a line fill; sampled only in IDLE.
- `fillCritWord`  in  [0:2]  index of the first (critical) word returned.
- `fillAbort`  in  1  PLB error or cancel; discards the fill in progress.
- `plbRdDAck`  in  1  one read-data word is valid this cycle.
- `plbRdData`  in  [0:31]  read-data word.
- `lookupReq`  in  1  load asks for a word from the buffer.
- `lookupWord`  in  [0:2]  index of the requested word.
- `bypassMuxOut`  out  [0:31]  forwarded word; registered.
- `bypassHit`  out  1  `bypassMuxOut` holds a valid requested word; registered.
- `fillBusy`  out  1  state is FILL or DRAIN.
- `arrayWrReq`  out  1  drain write request to the data array.
- `arrayWrWord`  out  [0:2]  word index of the current drain write.
- `arrayWrData`  out  [0:31]  data of the current drain write.
- `arrayWrAck`  in  1  data array accepted the current drain write.
- `fillDone`  out  1  one-cycle pulse when the drain completes.

## Operation
Storage: 8×32 data registers, 8 valid bits `wv[0:7]`, fill pointer `fPtr[0:2]`, fill counter `fCnt[0:3]`, drain pointer `dPtr[0:2]`.

State machine: IDLE, FILL, DRAIN.
- IDLE → FILL on `fillStart`. Same edge: `fPtr`←`fillCritWord`, `fCnt`←0, `wv`←0.
- FILL: on `plbRdDAck`, data[`fPtr`]←`plbRdData`, `wv[fPtr]`←1, `fPtr`←`fPtr`+1 (mod 8, wraps 7→0), `fCnt`←`fCnt`+1.
- FILL → DRAIN on the ack that makes `fCnt`=8. Same edge: `dPtr`←0.
- FILL → IDLE on `fillAbort`. Same edge: `wv`←0. No drain, no `fillDone`.
- DRAIN: `arrayWrReq`=1. `arrayWrWord`=`dPtr`. `arrayWrData`=data[`dPtr`], combinational from the buffer. On `arrayWrAck`, `dPtr`←`dPtr`+1.
- DRAIN → IDLE on the ack with `dPtr`=7. Same edge: `wv`←0 and `fillDone`←1 for the following cycle.

Ignored inputs and precedence:
- `fillStart` outside IDLE is ignored.
- `fillAbort` outside FILL is ignored.
- `plbRdDAck` outside FILL is ignored, including in the same cycle as `fillStart` in IDLE.
- `arrayWrAck` outside DRAIN is ignored.
- `fillAbort` and `plbRdDAck` in the same cycle: abort wins; the word is not written.

Bypass lookup, registered:
- Hit condition: `lookupReq`=1 and either `wv[lookupWord]`=1 or the current cycle's accepted `plbRdDAck` targets `lookupWord` (same-cycle forward). When this holds, next cycle `bypassHit`=1 and `bypassMuxOut`=that word.
- Otherwise, next cycle `bypassHit`=0 and `bypassMuxOut`=0.
- Hits remain possible throughout DRAIN.
- A lookup in the same cycle as the final drain ack still hits. `wv` clears on that edge, after the sample.

`fillBusy` = (state≠IDLE). It is decoded from registered state, so it has no combinational input path.

## Timing
- Reset (synchronous): state=IDLE and `wv`=0. `bypassMuxOut`=0, `bypassHit`=0, `fillBusy`=0, `arrayWrReq`=0, `arrayWrWord`=0, `arrayWrData`=0, `fillDone`=0.
- Reset overrides everything, including a mid-FILL or mid-DRAIN cycle. Buffer contents are discarded; no `fillDone`.
- `fillStart` on cycle N: `fillBusy`=1 and acks are accepted from cycle N+1.
- Acks may arrive back-to-back or with gaps; there is no timeout.
- Lookup to `bypassHit`/`bypassMuxOut`: 1 cycle.
- Last fill ack on cycle N: `arrayWrReq`=1 from N+1.
- `arrayWrReq`, `arrayWrWord` and `arrayWrData` hold stable until acked. With ack tied high the drain takes exactly 8 cycles.
- Last drain ack on cycle M: `fillDone`=1 and `fillBusy`=0 on M+1. A new `fillStart` is accepted on M+1.

## Test plan
- **Critical-word wrap:** reset; `fillStart` with `fillCritWord`=5; 8 consecutive acks carrying data 0xA0000005, …07, …00, …04. Required: words 5,6,7,0,…,4 are stored; `arrayWrReq` rises the cycle after the 8th ack.
- **Same-cycle forward:** during FILL, `lookupReq` with `lookupWord`=3 on the same cycle as the ack writing word 3 with data 0x12345678. Required: next cycle `bypassHit`=1 and `bypassMuxOut`=0x12345678. A lookup of a not-yet-filled word returns `bypassHit`=0.
- **Drain with stalls:** ack word 0 immediately, then withhold `arrayWrAck` for 3 cycles on word 1. Required: `arrayWrWord`=1 and its data held stable; 8 writes in order 0..7; `fillDone` is a single pulse the cycle after the 8th ack.
- **Abort:** `fillAbort` and `plbRdDAck` together after 4 words. Required: IDLE next cycle; `wv`=0; a subsequent lookup gives `bypassHit`=0; no `arrayWrReq`, no `fillDone`.
- **Ignored inputs:** `fillStart` during DRAIN; `plbRdDAck` in IDLE; `fillStart` and `plbRdDAck` in the same IDLE cycle. Required: no state or pointer change beyond the legal IDLE→FILL transition; no data written.
- **Mid-operation reset:** assert `reset` mid-DRAIN. Required: every output is 0 next cycle; a new fill then completes normally.

Source files
------------

// File: rtl/p405s_dcu_linefillbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | p405s_dcu_linefillbuf                                                      |
// | DCU line-fill buffer: captures an 8-word critical-word-first PLB fill,     |
// | forwards received words to the load bypass mux, then drains the line to    |
// | the data array through a req/ack handshake.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module p405s_dcu_linefillbuf #(
  parameter int LFB_WORDS = 8
) (
  input  logic        CB,
  input  logic        reset,
  input  logic        fillStart,
  input  logic [0:2]  fillCritWord,
  input  logic        fillAbort,
  input  logic        plbRdDAck,
  input  logic [0:31] plbRdData,
  input  logic        lookupReq,
  input  logic [0:2]  lookupWord,
  output logic [0:31] bypassMuxOut,
  output logic        bypassHit,
  output logic        fillBusy,
  output logic        arrayWrReq,
  output logic [0:2]  arrayWrWord,
  output logic [0:31] arrayWrData,
  input  logic        arrayWrAck,
  output logic        fillDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [0:31]          r_data [LFB_WORDS];
  logic [LFB_WORDS-1:0] r_wv;
  logic [2:0]           r_fPtr;
  logic [3:0]           r_fCnt;
  logic [2:0]           r_dPtr;

  logic w_ackAcc;
  logic w_drainAck;
  logic w_fwdHit;
  logic w_lookHit;

  // Abort outranks a same-cycle data ack, so the word is never written.
  assign w_ackAcc   = (r_state == ST_FILL) && plbRdDAck && !fillAbort;
  assign w_drainAck = (r_state == ST_DRAIN) && arrayWrAck;
  assign w_fwdHit   = w_ackAcc && (r_fPtr == lookupWord);
  assign w_lookHit  = lookupReq && (r_wv[lookupWord] || w_fwdHit);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (fillStart) w_stateNext = ST_FILL;
      ST_FILL: begin
        if (fillAbort)                         w_stateNext = ST_IDLE;
        else if (plbRdDAck && r_fCnt == 4'd7)  w_stateNext = ST_DRAIN;
      end
      ST_DRAIN: if (arrayWrAck && r_dPtr == 3'd7) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    fillBusy    = 1'b0;
    arrayWrReq  = 1'b0;
    arrayWrWord = 3'd0;
    arrayWrData = 32'd0;
    if (r_state != ST_IDLE) fillBusy = 1'b1;
    if (r_state == ST_DRAIN) begin
      arrayWrReq  = 1'b1;
      arrayWrWord = r_dPtr;
      arrayWrData = r_data[r_dPtr];
    end
  end

  always_ff @(posedge CB) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wv         <= '0;
      r_fPtr       <= 3'd0;
      r_fCnt       <= 4'd0;
      r_dPtr       <= 3'd0;
      bypassHit    <= 1'b0;
      bypassMuxOut <= 32'd0;
      fillDone     <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      fillDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fillStart) begin
            r_fPtr <= fillCritWord;
            r_fCnt <= 4'd0;
            r_wv   <= '0;
          end
        end
        ST_FILL: begin
          if (fillAbort) begin
            r_wv <= '0;
          end else if (plbRdDAck) begin
            r_wv[r_fPtr] <= 1'b1;
            r_fPtr       <= r_fPtr + 3'd1;
            r_fCnt       <= r_fCnt + 4'd1;
            if (r_fCnt == 4'd7) r_dPtr <= 3'd0;
          end
        end
        ST_DRAIN: begin
          if (arrayWrAck) begin
            r_dPtr <= r_dPtr + 3'd1;
            if (r_dPtr == 3'd7) begin
              r_wv     <= '0;
              fillDone <= 1'b1;
            end
          end
        end
        default: r_wv <= '0;
      endcase
      // Lookup samples wv before this edge's clear, so a final-ack lookup hits.
      bypassHit    <= w_lookHit;
      bypassMuxOut <= !w_lookHit ? 32'd0 : (w_fwdHit ? plbRdData : r_data[lookupWord]);
    end
  end

  always_ff @(posedge CB) begin
    if (w_ackAcc) r_data[r_fPtr] <= plbRdData;
  end

  logic w_unusedDrainAck;
  assign w_unusedDrainAck = w_drainAck;

endmodule
`default_nettype wire

// File: tb/tb_p405s_dcu_linefillbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_p405s_dcu_linefillbuf                                                   |
// | Scoreboard bench: transaction-level line model predicts every cycle.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_p405s_dcu_linefillbuf;

  logic        CB = 1'b0;
  logic        reset, fillStart, fillAbort, plbRdDAck, lookupReq, arrayWrAck;
  logic [0:2]  fillCritWord, lookupWord;
  logic [0:31] plbRdData;
  logic [0:31] bypassMuxOut, arrayWrData;
  logic        bypassHit, fillBusy, arrayWrReq, fillDone;
  logic [0:2]  arrayWrWord;

  p405s_dcu_linefillbuf #(.LFB_WORDS(8)) dut (
    .CB(CB), .reset(reset), .fillStart(fillStart), .fillCritWord(fillCritWord),
    .fillAbort(fillAbort), .plbRdDAck(plbRdDAck), .plbRdData(plbRdData),
    .lookupReq(lookupReq), .lookupWord(lookupWord), .bypassMuxOut(bypassMuxOut),
    .bypassHit(bypassHit), .fillBusy(fillBusy), .arrayWrReq(arrayWrReq),
    .arrayWrWord(arrayWrWord), .arrayWrData(arrayWrData), .arrayWrAck(arrayWrAck),
    .fillDone(fillDone)
  );

  always #5 CB = ~CB;

  typedef struct packed {
    logic        hit;
    logic [31:0] bdata;
    logic        busy;
    logic        req;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic        done;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  // Line model: 0 = no line in flight, 1 = collecting words, 2 = writing back
  int          mMode = 0;
  logic [31:0] mBuf[8];
  bit          mHave[8];
  int          mNext = 0, mCnt = 0, mDrain = 0;

  task automatic clearHave();
    for (int i = 0; i < 8; i++) mHave[i] = 1'b0;
  endtask

  task automatic idle();
    fillStart = 0; fillAbort = 0; plbRdDAck = 0; lookupReq = 0; arrayWrAck = 0;
    fillCritWord = 0; lookupWord = 0; plbRdData = 0;
  endtask

  // Predict outputs after the coming edge from the current inputs, then advance one cycle.
  task automatic step();
    exp_t e;
    bit   acc;
    int   lw;
    e   = '0;
    lw  = int'(lookupWord);
    acc = (mMode == 1) && plbRdDAck && !fillAbort;
    if (reset) begin
      mMode = 0;
      clearHave();
    end else begin
      if (lookupReq && (mHave[lw] || (acc && mNext == lw))) begin
        e.hit   = 1'b1;
        e.bdata = (acc && mNext == lw) ? plbRdData : mBuf[lw];
      end
      if (mMode == 0) begin
        if (fillStart) begin
          mMode = 1; mNext = int'(fillCritWord); mCnt = 0; clearHave();
        end
      end else if (mMode == 1) begin
        if (fillAbort) begin
          mMode = 0; clearHave();
        end else if (plbRdDAck) begin
          mBuf[mNext] = plbRdData; mHave[mNext] = 1'b1;
          mNext = (mNext + 1) % 8; mCnt++;
          if (mCnt == 8) begin mMode = 2; mDrain = 0; end
        end
      end else begin
        if (arrayWrAck) begin
          if (mDrain == 7) begin
            mMode = 0; clearHave(); e.done = 1'b1;
          end else mDrain++;
        end
      end
      e.busy  = (mMode != 0);
      e.req   = (mMode == 2);
      e.word  = (mMode == 2) ? 3'(mDrain) : 3'd0;
      e.wdata = (mMode == 2) ? mBuf[mDrain] : 32'd0;
    end
    expQ.push_back(e);
    @(negedge CB);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", n, act, req, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CB); #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("bypassHit",    32'(bypassHit),   32'(e.hit));
        chk("bypassMuxOut", bypassMuxOut,     e.bdata);
        chk("fillBusy",     32'(fillBusy),    32'(e.busy));
        chk("arrayWrReq",   32'(arrayWrReq),  32'(e.req));
        chk("arrayWrWord",  32'(arrayWrWord), 32'(e.word));
        chk("arrayWrData",  arrayWrData,      e.wdata);
        chk("fillDone",     32'(fillDone),    32'(e.done));
      end
    end
  end

  task automatic fillLine(input int crit, input logic [31:0] base);
    idle(); fillStart = 1; fillCritWord = 3'(crit); step();
    idle();
    for (int i = 0; i < 8; i++) begin
      plbRdDAck = 1; plbRdData = base | 32'((crit + i) % 8);
      lookupReq = 1; lookupWord = 3'($urandom);
      step();
    end
    idle();
  endtask

  task automatic drainAll(input int maxCyc);
    for (int i = 0; i < maxCyc && mMode == 2; i++) begin
      arrayWrAck = 1; lookupReq = 1; lookupWord = 3'(i); step();
    end
    idle();
  endtask

  initial begin : stim
    idle(); reset = 1;
    step(); step();
    reset = 0; step();

    // Critical-word wrap starting at word 5, back-to-back acks
    fillLine(5, 32'hA000_0000);
    step();
    drainAll(12); step();

    // Same-cycle forward and a miss on an unfilled word
    idle(); fillStart = 1; fillCritWord = 0; step(); idle();
    for (int i = 0; i < 8; i++) begin
      plbRdDAck = 1;
      plbRdData = (i == 3) ? 32'h1234_5678 : 32'hB000_0000 + 32'(i);
      lookupReq = (i == 3 || i == 1);
      lookupWord = (i == 3) ? 3'd3 : 3'd6;
      step();
    end
    idle();

    // Drain with a 3-cycle stall on word 1
    arrayWrAck = 1; step();
    arrayWrAck = 0; step(); step(); step();
    drainAll(12); step();

    // Abort together with an ack after four words
    fillLine(2, 32'hC000_0000);
    drainAll(12);
    idle(); fillStart = 1; fillCritWord = 6; step(); idle();
    for (int i = 0; i < 4; i++) begin plbRdDAck = 1; plbRdData = 32'hD000_0000 + 32'(i); step(); end
    fillAbort = 1; plbRdDAck = 1; plbRdData = 32'hDEAD_BEEF; lookupReq = 1; lookupWord = 2; step();
    idle(); lookupReq = 1; lookupWord = 6; step();
    lookupWord = 2; step(); idle(); step();

    // Ignored inputs: ack in IDLE, start+ack together, start during DRAIN
    plbRdDAck = 1; plbRdData = 32'h5555_5555; step();
    fillStart = 1; fillCritWord = 1; plbRdDAck = 1; plbRdData = 32'h6666_6666; step();
    idle();
    for (int i = 0; i < 8; i++) begin
      plbRdDAck = 1; plbRdData = 32'hE000_0000 + 32'(i); step();
      plbRdDAck = 0; step();
    end
    fillStart = 1; fillCritWord = 4; step();
    idle(); drainAll(12); step();

    // Reset mid-DRAIN, then a clean fill
    fillLine(7, 32'hF000_0000);
    arrayWrAck = 1; step(); step(); step();
    idle(); reset = 1; step(); reset = 0; step();
    fillLine(3, 32'h0F00_0000);
    drainAll(12); step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      fillStart    = ($urandom_range(0, 3) == 0);
      fillCritWord = 3'($urandom);
      fillAbort    = ($urandom_range(0, 39) == 0);
      plbRdDAck    = ($urandom_range(0, 2) != 0);
      plbRdData    = $urandom;
      lookupReq    = $urandom_range(0, 1) == 1;
      lookupWord   = 3'($urandom);
      arrayWrAck   = $urandom_range(0, 1) == 1;
      step();
    end
    idle(); reset = 0; step(); step();

    @(posedge CB); #2;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
